operand_fetch_ctrl: RTL and testbench

- Sequencer directly upstream of the 32x32 single-port register file.
- Arbitrates writeback requests and two-operand read requests onto the file's single sel/wr/datain port.
- Reads the two operands in sequence, compensating for the file's fixed read latency.
- Presents the operand pair to the execute stage over a valid/ready handshake.

---
 rtl/operand_fetch_ctrl_if.sv | 45 ++++
 rtl/operand_fetch_ctrl.sv | 129 ++++++++++++
 tb/tb_operand_fetch_ctrl.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/operand_fetch_ctrl_if.sv
// Bundle of request, writeback, register-file and operand
// channels around the operand fetch sequencer.
interface operand_fetch_ctrl_if #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32
) ();
   logic              req_valid;
   logic              req_ready;
   logic [ADDR_W-1:0] req_rs;
   logic [ADDR_W-1:0] req_rt;
   logic              wb_valid;
   logic              wb_ready;
   logic [ADDR_W-1:0] wb_sel;
   logic [DATA_W-1:0] wb_data;
   logic [ADDR_W-1:0] rf_sel;
   logic              rf_wr;
   logic [DATA_W-1:0] rf_wdata;
   logic [DATA_W-1:0] rf_rdata;
   logic              op_valid;
   logic              op_ready;
   logic [DATA_W-1:0] op_a;
   logic [DATA_W-1:0] op_b;

   modport slave (
      input  req_valid, req_rs, req_rt,
      output req_ready,
      input  wb_valid, wb_sel, wb_data,
      output wb_ready,
      output rf_sel, rf_wr, rf_wdata,
      input  rf_rdata,
      output op_valid, op_a, op_b,
      input  op_ready
   );

   modport master (
      output req_valid, req_rs, req_rt,
      input  req_ready,
      output wb_valid, wb_sel, wb_data,
      input  wb_ready,
      input  rf_sel, rf_wr, rf_wdata,
      output rf_rdata,
      input  op_valid, op_a, op_b,
      output op_ready
   );
endinterface

// File: rtl/operand_fetch_ctrl.sv
// Sequences writebacks and two-operand reads onto the single
// register-file port, then hands the operand pair to execute.
module operand_fetch_ctrl #(
   parameter int ADDR_W = 5,
   parameter int DATA_W = 32,
   parameter int RD_LAT = 2
) (
   input logic clk,
   input logic reset,
   operand_fetch_ctrl_if.slave bus
);

   typedef enum logic [2:0] {
      IDLE, WRITE, RD_A, RD_B, OUT
   } state_t;

   localparam logic [2:0] LAST = 3'(RD_LAT - 1);

   state_t            state, state_n;
   logic [2:0]        cnt, cnt_n;
   logic [ADDR_W-1:0] sel_q, sel_n;
   logic [ADDR_W-1:0] rt_q, rt_n;
   logic              same_q, same_n;
   logic              wr_q, wr_n;
   logic [DATA_W-1:0] wdata_q, wdata_n;
   logic              ov_q, ov_n;
   logic [DATA_W-1:0] a_q, a_n;
   logic [DATA_W-1:0] b_q, b_n;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= '0;
         sel_q   <= '0;
         rt_q    <= '0;
         same_q  <= 1'b0;
         wr_q    <= 1'b0;
         wdata_q <= '0;
         ov_q    <= 1'b0;
         a_q     <= '0;
         b_q     <= '0;
      end else begin
         state   <= state_n;
         cnt     <= cnt_n;
         sel_q   <= sel_n;
         rt_q    <= rt_n;
         same_q  <= same_n;
         wr_q    <= wr_n;
         wdata_q <= wdata_n;
         ov_q    <= ov_n;
         a_q     <= a_n;
         b_q     <= b_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      sel_n   = sel_q;
      rt_n    = rt_q;
      same_n  = same_q;
      wr_n    = 1'b0;
      wdata_n = wdata_q;
      ov_n    = ov_q;
      a_n     = a_q;
      b_n     = b_q;
      unique case (state)
         IDLE: begin
            // writeback always wins over a pending read
            if (bus.wb_valid) begin
               sel_n   = bus.wb_sel;
               wdata_n = bus.wb_data;
               wr_n    = 1'b1;
               state_n = WRITE;
            end else if (bus.req_valid) begin
               sel_n   = bus.req_rs;
               rt_n    = bus.req_rt;
               same_n  = (bus.req_rs == bus.req_rt);
               cnt_n   = '0;
               state_n = RD_A;
            end
         end
         WRITE: state_n = IDLE;
         RD_A: begin
            if (cnt == LAST) begin
               a_n   = bus.rf_rdata;
               cnt_n = '0;
               if (same_q) begin
                  b_n     = bus.rf_rdata;
                  ov_n    = 1'b1;
                  state_n = OUT;
               end else begin
                  sel_n   = rt_q;
                  state_n = RD_B;
               end
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         RD_B: begin
            if (cnt == LAST) begin
               b_n     = bus.rf_rdata;
               cnt_n   = '0;
               ov_n    = 1'b1;
               state_n = OUT;
            end else begin
               cnt_n = cnt + 3'd1;
            end
         end
         OUT: begin
            if (bus.op_ready) begin
               ov_n    = 1'b0;
               state_n = IDLE;
            end
         end
         default: state_n = IDLE;
      endcase
   end

   assign bus.wb_ready  = (state == IDLE);
   assign bus.req_ready = (state == IDLE) && !bus.wb_valid;
   assign bus.rf_sel    = sel_q;
   assign bus.rf_wr     = wr_q;
   assign bus.rf_wdata  = wdata_q;
   assign bus.op_valid  = ov_q;
   assign bus.op_a      = a_q;
   assign bus.op_b      = b_q;

endmodule

// File: tb/tb_operand_fetch_ctrl.sv
// Runs three controllers (RD_LAT 2, 1, 7) in lockstep, each
// against its own latency-matched register file model.
module tb_operand_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid;
   logic [4:0]  req_rs, req_rt;
   logic        wb_valid;
   logic [4:0]  wb_sel;
   logic [31:0] wb_data;
   logic        op_ready;

   logic        rq_rdy [3];
   logic        wb_rdy [3];
   logic        opv    [3];
   logic        rfwr   [3];
   logic [4:0]  rfsel  [3];
   logic [31:0] rfwd   [3];
   logic [31:0] opa    [3];
   logic [31:0] opb    [3];
   int          lat    [3];
   int          wrc    [3];
   int          selc   [3];
   int          unst   [3];
   int          lats   [3];

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < 3; g++) begin : gi
      localparam int L = (g == 0) ? 2 : (g == 1) ? 1 : 7;
      operand_fetch_ctrl_if #(.ADDR_W(5), .DATA_W(32)) bus ();
      operand_fetch_ctrl #(
         .ADDR_W(5), .DATA_W(32), .RD_LAT(L)
      ) dut (
         .clk(clk),
         .reset(reset),
         .bus(bus)
      );

      logic [31:0] mem [32];
      logic [4:0]  hist [7];
      int          l_lat = 0, l_wrc = 0, l_selc = 0, l_unst = 0;
      logic        run = 1'b0, hold_q = 1'b0;
      logic [4:0]  sel_q = '0;
      logic [31:0] a_q = '0, b_q = '0;

      initial begin
         for (int i = 0; i < 32; i++) mem[i] = 32'hC000_0000 | i;
         mem[3] = 32'h1234_5678;
         mem[7] = 32'hA5A5_A5A5;
         for (int i = 0; i < 7; i++) hist[i] = '0;
      end

      always @(posedge clk) begin
         if (bus.rf_wr) mem[bus.rf_sel] <= bus.rf_wdata;
         hist[0] <= bus.rf_sel;
         for (int k = 1; k < 7; k++) hist[k] <= hist[k-1];
      end

      if (L == 1) begin : comb_rd
         assign bus.rf_rdata = mem[bus.rf_sel];
      end else begin : pipe_rd
         assign bus.rf_rdata = mem[hist[L-2]];
      end

      assign bus.req_valid = req_valid;
      assign bus.req_rs    = req_rs;
      assign bus.req_rt    = req_rt;
      assign bus.wb_valid  = wb_valid;
      assign bus.wb_sel    = wb_sel;
      assign bus.wb_data   = wb_data;
      assign bus.op_ready  = op_ready;

      // edges after accept that still see op_valid low
      always @(posedge clk) begin
         if (bus.rf_wr) l_wrc <= l_wrc + 1;
         if (bus.rf_sel != sel_q) l_selc <= l_selc + 1;
         sel_q <= bus.rf_sel;
         if (req_valid && bus.req_ready) begin
            l_lat <= 0;
            run   <= 1'b1;
         end else if (run) begin
            if (!bus.op_valid) l_lat <= l_lat + 1;
            else run <= 1'b0;
         end
         if (hold_q && (!bus.op_valid || bus.op_a != a_q ||
             bus.op_b != b_q || bus.req_ready || bus.wb_ready))
            l_unst <= l_unst + 1;
         hold_q <= bus.op_valid && !op_ready;
         a_q    <= bus.op_a;
         b_q    <= bus.op_b;
      end

      assign rq_rdy[g] = bus.req_ready;
      assign wb_rdy[g] = bus.wb_ready;
      assign opv[g]    = bus.op_valid;
      assign rfwr[g]   = bus.rf_wr;
      assign rfsel[g]  = bus.rf_sel;
      assign rfwd[g]   = bus.rf_wdata;
      assign opa[g]    = bus.op_a;
      assign opb[g]    = bus.op_b;
      assign lat[g]    = l_lat;
      assign wrc[g]    = l_wrc;
      assign selc[g]   = l_selc;
      assign unst[g]   = l_unst;
      assign lats[g]   = L;
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s got %h want %h", nm, act, exp);
      end
   endtask

   task automatic chk_idle_zero(string tag);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("%s_sel_%0d", tag, g), 32'(rfsel[g]), 0);
         chk($sformatf("%s_wr_%0d", tag, g), 32'(rfwr[g]), 0);
         chk($sformatf("%s_wd_%0d", tag, g), rfwd[g], 0);
         chk($sformatf("%s_ov_%0d", tag, g), 32'(opv[g]), 0);
         chk($sformatf("%s_a_%0d", tag, g), opa[g], 0);
         chk($sformatf("%s_b_%0d", tag, g), opb[g], 0);
         chk($sformatf("%s_rqr_%0d", tag, g), 32'(rq_rdy[g]), 1);
         chk($sformatf("%s_wbr_%0d", tag, g), 32'(wb_rdy[g]), 1);
      end
   endtask

   typedef struct {
      logic        do_wb;
      logic [4:0]  wsel;
      logic [31:0] wdata;
      logic [4:0]  rs;
      logic [4:0]  rt;
      logic [31:0] ea;
      logic [31:0] eb;
      int          mul;
   } vec_t;

   vec_t vt [6];
   int   w0 [3];
   int   s0 [3];
   logic [4:0] ptrack;
   int   exp_sc;

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1, "timeout");
   end

   initial begin
      vt[0] = '{1'b1, 5'd5, 32'hDEAD_BEEF, 5'd5, 5'd3,
                32'hDEAD_BEEF, 32'h1234_5678, 2};
      vt[1] = '{1'b0, 5'd0, 32'h0, 5'd7, 5'd7,
                32'hA5A5_A5A5, 32'hA5A5_A5A5, 1};
      vt[2] = '{1'b1, 5'd0, 32'h0BAD_F00D, 5'd0, 5'd7,
                32'h0BAD_F00D, 32'hA5A5_A5A5, 2};
      vt[3] = '{1'b0, 5'd0, 32'h0, 5'd3, 5'd5,
                32'h1234_5678, 32'hDEAD_BEEF, 2};
      vt[4] = '{1'b1, 5'd9, 32'h1111_2222, 5'd9, 5'd9,
                32'h1111_2222, 32'h1111_2222, 1};
      vt[5] = '{1'b0, 5'd0, 32'h0, 5'd31, 5'd1,
                32'hC000_001F, 32'hC000_0001, 2};

      reset = 1'b1;
      req_valid = 0; req_rs = 0; req_rt = 0;
      wb_valid = 0; wb_sel = 0; wb_data = 0;
      op_ready = 0;
      repeat (2) @(negedge clk);
      chk_idle_zero("rst");
      reset = 1'b0;

      // abandon a read while instance 0 sits in RD_B
      @(negedge clk);
      req_rs = 5'd1; req_rt = 5'd2; req_valid = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rdb_sel", 32'(rfsel[0]), 2);
      chk("rdb_ov1", 32'(opv[1]), 1);
      for (int g = 0; g < 3; g++) w0[g] = wrc[g];
      #1 reset = 1'b1;
      #1 chk_idle_zero("mid");
      @(negedge clk);
      reset = 1'b0;
      repeat (3) @(negedge clk);
      for (int g = 0; g < 3; g++) begin
         chk($sformatf("post_ov_%0d", g), 32'(opv[g]), 0);
         chk($sformatf("post_wr_%0d", g), wrc[g] - w0[g], 0);
      end
      ptrack = 5'd0;

      for (int v = 0; v < 6; v++) begin
         for (int g = 0; g < 3; g++) begin
            w0[g] = wrc[g];
            s0[g] = selc[g];
         end
         exp_sc = 0;
         req_rs = vt[v].rs;
         req_rt = vt[v].rt;
         req_valid = 1'b1;
         if (vt[v].do_wb) begin
            wb_valid = 1'b1;
            wb_sel = vt[v].wsel;
            wb_data = vt[v].wdata;
            #1;
            for (int g = 0; g < 3; g++) begin
               chk($sformatf("v%0d_both_wbr_%0d", v, g), 32'(wb_rdy[g]), 1);
               chk($sformatf("v%0d_both_rqr_%0d", v, g), 32'(rq_rdy[g]), 0);
            end
            @(negedge clk);
            wb_valid = 1'b0;
            for (int g = 0; g < 3; g++) begin
               chk($sformatf("v%0d_wr_%0d", v, g), 32'(rfwr[g]), 1);
               chk($sformatf("v%0d_wsel_%0d", v, g), 32'(rfsel[g]), 32'(vt[v].wsel));
               chk($sformatf("v%0d_wdat_%0d", v, g), rfwd[g], vt[v].wdata);
               chk($sformatf("v%0d_wrq_%0d", v, g), 32'(rq_rdy[g]), 0);
            end
            @(negedge clk);
            for (int g = 0; g < 3; g++) begin
               chk($sformatf("v%0d_wr0_%0d", v, g), 32'(rfwr[g]), 0);
               chk($sformatf("v%0d_idle_rqr_%0d", v, g), 32'(rq_rdy[g]), 1);
            end
            if (ptrack != vt[v].wsel) exp_sc++;
            ptrack = vt[v].wsel;
         end else begin
            #1;
            chk($sformatf("v%0d_rqr", v), 32'(rq_rdy[0]), 1);
         end
         if (ptrack != vt[v].rs) exp_sc++;
         if (vt[v].rs != vt[v].rt) exp_sc++;
         @(negedge clk);
         req_valid = 1'b0;
         // a writeback offered during the read must not be taken
         wb_valid = 1'b1;
         wb_sel = 5'd30;
         wb_data = 32'hFFFF_FFFF;
         repeat (16) @(negedge clk);
         wb_valid = 1'b0;
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("v%0d_ov_%0d", v, g), 32'(opv[g]), 1);
            chk($sformatf("v%0d_a_%0d", v, g), opa[g], vt[v].ea);
            chk($sformatf("v%0d_b_%0d", v, g), opb[g], vt[v].eb);
            chk($sformatf("v%0d_lat_%0d", v, g), lat[g], vt[v].mul * lats[g]);
            chk($sformatf("v%0d_unst_%0d", v, g), unst[g], 0);
            chk($sformatf("v%0d_nwr_%0d", v, g), wrc[g] - w0[g], 32'(vt[v].do_wb));
            chk($sformatf("v%0d_selc_%0d", v, g), selc[g] - s0[g], exp_sc);
            chk($sformatf("v%0d_orq_%0d", v, g), 32'(rq_rdy[g]), 0);
            chk($sformatf("v%0d_owb_%0d", v, g), 32'(wb_rdy[g]), 0);
         end
         op_ready = 1'b1;
         @(negedge clk);
         op_ready = 1'b0;
         for (int g = 0; g < 3; g++) begin
            chk($sformatf("v%0d_done_ov_%0d", v, g), 32'(opv[g]), 0);
            chk($sformatf("v%0d_done_rqr_%0d", v, g), 32'(rq_rdy[g]), 1);
         end
         ptrack = vt[v].rt;
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
